// File: rtl/rbz_spi_pkg.sv
// rbz_spi_pkg: shared types and constants for the raybox-zero SPI host.
// Holds the host FSM state encoding, bus target codes and default widths.
package rbz_spi_pkg;

    localparam int DEF_MAX_BITS = 96;
    localparam int DEF_LEN_W    = 7;
    localparam int DEF_DIV_W    = 8;

    localparam logic TGT_VEC = 1'b0;
    localparam logic TGT_REG = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/rbz_spi_phase_timer.sv
// rbz_spi_phase_timer: loadable down-counter timing one SCLK phase.
// Ports: clk_i, rst_i (sync, active-high), load_i (force reload),
//        div_i (reload value D), tick_o (high while the count is 0).
module rbz_spi_phase_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = (cnt_q == '0);

    // Reloading on tick makes every phase last exactly D+1 clocks.
    always_comb begin
        cnt_d = cnt_q - DIV_W'(1);
        if (load_i || tick_o) begin
            cnt_d = div_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rbz_spi_host.sv
// rbz_spi_host: SPI mode-0 host for the raybox-zero vec and reg ports.
// Ports: i_clk, i_reset (sync, active-high); handshake i_valid/o_ready;
//        payload i_target, i_len, i_data (MSB-aligned), i_div (phase D);
//        status o_busy, o_done; buses o_vec_{csb,sclk,mosi},
//        o_reg_{csb,sclk,mosi}.
// Build option RBZ_SPI_HOST_VBLANK_GATE_EN adds i_vblank, which gates
// o_ready so frames only start during vertical blanking.
module rbz_spi_host
    import rbz_spi_pkg::*;
#(
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
`ifdef RBZ_SPI_HOST_VBLANK_GATE_EN
    input  logic                i_vblank,
`endif
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_target,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [DIV_W-1:0]    i_div,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_vec_csb,
    output logic                o_vec_sclk,
    output logic                o_vec_mosi,
    output logic                o_reg_csb,
    output logic                o_reg_sclk,
    output logic                o_reg_mosi
);

    state_e              state_q, state_d;
    logic                tgt_q, tgt_d;
    logic [LEN_W-1:0]    bits_q, bits_d;
    logic [MAX_BITS-1:0] sh_q, sh_d;
    logic [DIV_W-1:0]    div_q, div_d;

    logic             gate;
    logic             accept;
    logic             tick;
    logic [LEN_W-1:0] len_c;
    logic             frm;
    logic             sclk_w;
    logic             mosi_w;
    logic             sel_vec;
    logic             sel_reg;

`ifdef RBZ_SPI_HOST_VBLANK_GATE_EN
    assign gate = i_vblank;
`else
    assign gate = 1'b1;
`endif

    assign o_ready = (state_q == IDLE) && gate && !i_reset;
    assign accept  = i_valid && o_ready;

    assign len_c = (i_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : i_len;

    rbz_spi_phase_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk_i (i_clk),
        .rst_i (i_reset),
        .load_i(accept),
        .div_i (accept ? i_div : div_q),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        bits_d  = bits_q;
        sh_d    = sh_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d   = i_target;
                    div_d   = i_div;
                    sh_d    = i_data;
                    bits_d  = len_c;
                    state_d = (len_c == '0) ? DONE : LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = HI;
                end
            end
            HI: begin
                // Shift on the falling edge so mosi only moves with sclk low.
                if (tick) begin
                    state_d = LO;
                    bits_d  = bits_q - LEN_W'(1);
                    sh_d    = {sh_q[MAX_BITS-2:0], 1'b0};
                end
            end
            LO: begin
                if (tick) begin
                    state_d = (bits_q == '0) ? GAP : HI;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            tgt_q   <= TGT_VEC;
            bits_q  <= '0;
            sh_q    <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            bits_q  <= bits_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
        end
    end

    assign frm    = (state_q == LEAD) || (state_q == HI) || (state_q == LO);
    assign sclk_w = (state_q == HI);
    // The final LO phase (no bits left) drives mosi low during csb hold.
    assign mosi_w = frm && (bits_q != '0) && sh_q[MAX_BITS-1];

    assign sel_vec = frm && (tgt_q == TGT_VEC) && !i_reset;
    assign sel_reg = frm && (tgt_q == TGT_REG) && !i_reset;

    assign o_vec_csb  = !sel_vec;
    assign o_vec_sclk = sel_vec && sclk_w;
    assign o_vec_mosi = sel_vec && mosi_w;
    assign o_reg_csb  = !sel_reg;
    assign o_reg_sclk = sel_reg && sclk_w;
    assign o_reg_mosi = sel_reg && mosi_w;

    assign o_busy = (state_q != IDLE) && (state_q != DONE) && !i_reset;
    assign o_done = (state_q == DONE) && !i_reset;

endmodule
